// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding, coin values and price lookup for the vending sequencer
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        RETURN = 2'd2
    } vend_state_t;

    localparam logic [7:0] COIN5_VAL   = 8'd5;
    localparam logic [7:0] COIN10_VAL  = 8'd10;
    localparam logic [7:0] COIN50_VAL  = 8'd50;
    localparam logic [7:0] CHANGE_UNIT = 8'd5;

    function automatic logic [7:0] price_lookup(
        input logic [1:0] sel,
        input logic [7:0] p0,
        input logic [7:0] p1,
        input logic [7:0] p2,
        input logic [7:0] p3
    );
        case (sel)
            2'd0:    price_lookup = p0;
            2'd1:    price_lookup = p1;
            2'd2:    price_lookup = p2;
            default: price_lookup = p3;
        endcase
    endfunction

endpackage

// File: rtl/credit_to_bcd.sv
// rtl/credit_to_bcd.sv - registered binary to two-digit BCD for 0-99, one cycle latency
module credit_to_bcd (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] clamped;
    logic [3:0] tens_c;
    logic [6:0] tens_x10;
    logic [6:0] ones_w;

    // Out-of-range inputs saturate so both digits always stay in 0-9.
    always_comb begin
        clamped = (bin > 7'd99) ? 7'd99 : bin;
        tens_c  = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            if (clamped >= 7'(10 * k)) begin
                tens_c = 4'(k);
            end
        end
        tens_x10 = {3'b000, tens_c} * 7'd10;
        ones_w   = clamped - tens_x10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else begin
            tens <= tens_c;
            ones <= ones_w[3:0];
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - credit, purchase and timed change-return controller for the vending machine
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 100000000,
    parameter int unsigned MAX_CREDIT  = 95,
    parameter int unsigned PRICE0      = 60,
    parameter int unsigned PRICE1      = 30,
    parameter int unsigned PRICE2      = 25,
    parameter int unsigned PRICE3      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       coin50,
    input  logic       buy_valid,
    input  logic [1:0] buy_sel,
    input  logic       cancel,
    output logic [6:0] credit,
    output logic [3:0] avail,
    output logic       dispense,
    output logic [1:0] item,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       buy_denied,
    output logic       busy,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    localparam int unsigned   CNT_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [7:0]    MAX_C     = 8'(MAX_CREDIT);
    localparam logic [7:0]    P0        = 8'(PRICE0);
    localparam logic [7:0]    P1        = 8'(PRICE1);
    localparam logic [7:0]    P2        = 8'(PRICE2);
    localparam logic [7:0]    P3        = 8'(PRICE3);

    vend_state_t      state, state_nxt;
    logic [6:0]       credit_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       sel_q, sel_nxt;
    logic [1:0]       item_nxt;

    logic [7:0] credit8;
    logic [7:0] coin_sum;
    logic [7:0] coin_total;
    logic [7:0] price_req;
    logic [7:0] price_vend;
    logic [7:0] remainder;
    logic [7:0] refunded;
    logic       any_coin;
    logic       coin_ok;

    assign credit8    = {1'b0, credit};
    assign coin_sum   = (coin5  ? COIN5_VAL  : 8'd0)
                      + (coin10 ? COIN10_VAL : 8'd0)
                      + (coin50 ? COIN50_VAL : 8'd0);
    assign coin_total = credit8 + coin_sum;
    assign any_coin   = coin5 | coin10 | coin50;
    assign price_req  = price_lookup(buy_sel, P0, P1, P2, P3);
    assign price_vend = price_lookup(sel_q, P0, P1, P2, P3);
    assign remainder  = credit8 - price_vend;
    assign refunded   = credit8 - CHANGE_UNIT;

    assign busy     = (state != IDLE);
    assign avail[0] = (credit8 >= P0);
    assign avail[1] = (credit8 >= P1);
    assign avail[2] = (credit8 >= P2);
    assign avail[3] = (credit8 >= P3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            credit <= 7'd0;
            cnt    <= '0;
            sel_q  <= 2'd0;
            item   <= 2'd0;
        end else begin
            state  <= state_nxt;
            credit <= credit_nxt;
            cnt    <= cnt_nxt;
            sel_q  <= sel_nxt;
            item   <= item_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit;
        cnt_nxt      = cnt;
        sel_nxt      = sel_q;
        item_nxt     = item;
        dispense     = 1'b0;
        change_pulse = 1'b0;
        coin_reject  = 1'b0;
        buy_denied   = 1'b0;
        coin_ok      = 1'b1;

        case (state)
            IDLE: begin
                // Priority: cancel, then buy, then coins; an accepted event swallows the coins.
                if (cancel && (credit != 7'd0)) begin
                    state_nxt = RETURN;
                    cnt_nxt   = '0;
                    coin_ok   = 1'b0;
                end else if (buy_valid) begin
                    if (credit8 >= price_req) begin
                        state_nxt = VEND;
                        sel_nxt   = buy_sel;
                        coin_ok   = 1'b0;
                    end else begin
                        buy_denied = 1'b1;
                    end
                end
                if (any_coin) begin
                    if (!coin_ok || (coin_total > MAX_C)) begin
                        coin_reject = 1'b1;
                    end else begin
                        credit_nxt = coin_total[6:0];
                    end
                end
            end

            VEND: begin
                coin_reject = any_coin;
                dispense    = 1'b1;
                credit_nxt  = remainder[6:0];
                item_nxt    = sel_q;
                cnt_nxt     = '0;
                state_nxt   = (remainder != 8'd0) ? RETURN : IDLE;
            end

            RETURN: begin
                coin_reject = any_coin;
                if (cnt == TICK_LAST) begin
                    change_pulse = 1'b1;
                    credit_nxt   = refunded[6:0];
                    cnt_nxt      = '0;
                    if (refunded == 8'd0) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    credit_to_bcd u_bcd (
        .clk  (clk),
        .rst  (rst),
        .bin  (credit),
        .tens (bcd_tens),
        .ones (bcd_ones)
    );

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - scoreboard bench for vend_sequencer with TICK_CYCLES=4
module tb_vend_sequencer;

    localparam int EV_DISPENSE = 0;
    localparam int EV_CHANGE   = 1;
    localparam int EV_REJECT   = 2;
    localparam int EV_DENIED   = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin5 = 1'b0, coin10 = 1'b0, coin50 = 1'b0;
    logic       buy_valid = 1'b0;
    logic [1:0] buy_sel = 2'd0;
    logic       cancel = 1'b0;
    logic [6:0] credit;
    logic [3:0] avail;
    logic       dispense;
    logic [1:0] item;
    logic       change_pulse;
    logic       coin_reject;
    logic       buy_denied;
    logic       busy;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    vend_sequencer #(
        .TICK_CYCLES (4),
        .MAX_CREDIT  (95),
        .PRICE0      (60),
        .PRICE1      (30),
        .PRICE2      (25),
        .PRICE3      (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin5        (coin5),
        .coin10       (coin10),
        .coin50       (coin50),
        .buy_valid    (buy_valid),
        .buy_sel      (buy_sel),
        .cancel       (cancel),
        .credit       (credit),
        .avail        (avail),
        .dispense     (dispense),
        .item         (item),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .buy_denied   (buy_denied),
        .busy         (busy),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind %0d credit %0d expected none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                bad++;
                $display("FAIL event: got kind %0d credit %0d expected kind %0d credit %0d",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dispense)     pop_cmp(EV_DISPENSE, int'(credit));
            if (change_pulse) pop_cmp(EV_CHANGE,   int'(credit));
            if (coin_reject)  pop_cmp(EV_REJECT,   int'(credit));
            if (buy_denied)   pop_cmp(EV_DENIED,   int'(credit));
        end
    end

    task automatic cycle_in(input logic c5, input logic c10, input logic c50,
                            input logic buy, input logic [1:0] sel, input logic can);
        @(posedge clk);
        #1;
        coin5 = c5; coin10 = c10; coin50 = c50;
        buy_valid = buy; buy_sel = sel; cancel = can;
        @(posedge clk);
        #1;
        coin5 = 1'b0; coin10 = 1'b0; coin50 = 1'b0;
        buy_valid = 1'b0; buy_sel = 2'd0; cancel = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
        end
    endtask

    initial begin
        int n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_credit", int'(credit), 0);
        chk("reset_avail", int'(avail), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_bcd", int'({bcd_tens, bcd_ones}), 0);
        chk("reset_pulses", int'({dispense, change_pulse, coin_reject, buy_denied}), 0);

        cycle_in(0, 0, 1, 0, 2'd0, 0);
        cycle_in(0, 1, 0, 0, 2'd0, 0);
        chk("credit_60", int'(credit), 60);
        chk("avail_60", int'(avail), 4'b1111);
        chk("bcd_lag_tens", int'(bcd_tens), 5);
        @(posedge clk);
        #1;
        chk("bcd_tens_60", int'(bcd_tens), 6);
        chk("bcd_ones_60", int'(bcd_ones), 0);

        expect_ev(EV_DISPENSE, 60);
        for (int c = 30; c > 0; c -= 5) expect_ev(EV_CHANGE, c);
        cycle_in(0, 0, 0, 1, 2'd1, 0);
        chk("vend_busy", int'(busy), 1);
        wait_idle(n);
        chk("return_cycles", n, 25);
        chk("after_vend_credit", int'(credit), 0);
        chk("after_vend_item", int'(item), 1);
        chk("after_vend_busy", int'(busy), 0);

        cycle_in(1, 1, 1, 0, 2'd0, 0);
        chk("coins_together", int'(credit), 65);
        cycle_in(0, 1, 0, 0, 2'd0, 0);
        cycle_in(0, 1, 0, 0, 2'd0, 0);
        cycle_in(1, 0, 0, 0, 2'd0, 0);
        chk("credit_90", int'(credit), 90);
        expect_ev(EV_REJECT, 90);
        cycle_in(0, 1, 0, 0, 2'd0, 0);
        chk("reject_keeps_90", int'(credit), 90);
        cycle_in(1, 0, 0, 0, 2'd0, 0);
        chk("credit_max_95", int'(credit), 95);
        @(posedge clk);
        #1;
        chk("bcd_95", int'({bcd_tens, bcd_ones}), 8'h95);
        expect_ev(EV_REJECT, 95);
        cycle_in(1, 0, 0, 0, 2'd0, 0);
        chk("full_reject", int'(credit), 95);
        for (int c = 95; c > 0; c -= 5) expect_ev(EV_CHANGE, c);
        cycle_in(0, 0, 0, 0, 2'd0, 1);
        wait_idle(n);
        chk("refund_95_cycles", n, 76);
        chk("refund_95_credit", int'(credit), 0);

        cycle_in(0, 1, 0, 0, 2'd0, 0);
        cycle_in(0, 1, 0, 0, 2'd0, 0);
        chk("avail_20", int'(avail), 4'b1000);
        expect_ev(EV_DENIED, 20);
        cycle_in(0, 0, 0, 1, 2'd0, 0);
        chk("denied_credit", int'(credit), 20);
        chk("denied_busy", int'(busy), 0);

        cycle_in(1, 0, 0, 0, 2'd0, 0);
        chk("credit_25", int'(credit), 25);
        expect_ev(EV_REJECT, 25);
        cycle_in(1, 0, 0, 1, 2'd3, 1);
        chk("cancel_wins_busy", int'(busy), 1);
        expect_ev(EV_REJECT, 25);
        for (int c = 25; c > 0; c -= 5) expect_ev(EV_CHANGE, c);
        cycle_in(0, 1, 0, 1, 2'd3, 0);
        wait_idle(n);
        chk("cancel_25_credit", int'(credit), 0);
        chk("cancel_25_item", int'(item), 1);

        cycle_in(0, 1, 0, 0, 2'd0, 0);
        cycle_in(1, 0, 0, 0, 2'd0, 0);
        chk("credit_15", int'(credit), 15);
        cycle_in(0, 0, 0, 0, 2'd0, 1);
        chk("return_15_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_item", int'(item), 0);
        chk("rst_bcd", int'({bcd_tens, bcd_ones}), 0);
        chk("rst_pulses", int'({dispense, change_pulse, coin_reject, buy_denied}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        cycle_in(0, 0, 0, 0, 2'd0, 1);
        chk("cancel_zero_busy", int'(busy), 0);
        repeat (8) @(posedge clk);
        #1;
        chk("cancel_zero_credit", int'(credit), 0);
        chk("cancel_zero_idle", int'(busy), 0);

        repeat (2) @(posedge clk);
        #1;
        chk("events_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Controller that sequences the vending-machine credit datapath: accepts one-pulse coin, purchase and cancel events, owns the credit register, deducts prices, and schedules timed change return at one 5-unit coin per tick.
- Sits between the debounce/OnePulse and keyboard-decoder front end and the LED and seven-segment back end.
- Arbitrates simultaneous events with a fixed priority and exports registered BCD credit for display.

Parameters:
- TICK_CYCLES, 100000000, clk cycles between change pulses in RETURN (bench uses 4).
- MAX_CREDIT, 95, credit ceiling; must be a multiple of 5 and <= 99.
- PRICE0, 60, price of item 0 (coffee).
- PRICE1, 30, price of item 1 (coke).
- PRICE2, 25, price of item 2 (oolong).
- PRICE3, 20, price of item 3 (water).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- coin5  in  1  one-cycle pulse, 5 inserted.
- coin10  in  1  one-cycle pulse, 10 inserted.
- coin50  in  1  one-cycle pulse, 50 inserted.
- buy_valid  in  1  one-cycle purchase request.
- buy_sel  in  2  item index, sampled with buy_valid.
- cancel  in  1  one-cycle pulse, return all credit.
- credit  out  7  current credit, binary.
- avail  out  4  avail[i] = credit >= PRICEi.
- dispense  out  1  one-cycle pulse, item vended.
- item  out  2  index of last vended item, held.
- change_pulse  out  1  one-cycle pulse per 5 returned.
- coin_reject  out  1  one-cycle pulse, a coin was refused.
- buy_denied  out  1  one-cycle pulse, purchase refused.
- busy  out  1  high in VEND or RETURN.
- bcd_tens  out  4  tens digit of credit.
- bcd_ones  out  4  ones digit of credit.

Behaviour:
- Reset is asynchronous and active-high on rst. One clock, clk.
- Reset values: all outputs and registers 0; state IDLE; tick counter 0.
- Mid-operation reset aborts any VEND or RETURN immediately.
- States are IDLE, VEND and RETURN.

IDLE, events resolved per cycle in this priority order:
- cancel: with credit > 0, go to RETURN and clear the tick counter. With credit 0, cancel is ignored.
- buy_valid: if credit >= PRICE[buy_sel], go to VEND and latch buy_sel. Otherwise pulse buy_denied and stay in IDLE.
- coins: add the sum of all coins asserted this cycle (5/10/50 can coincide, giving up to 65). If credit + sum > MAX_CREDIT, reject the whole sum: credit is unchanged and coin_reject pulses.
- Coins arriving in the same cycle as an accepted cancel or buy are rejected (coin_reject pulses).

VEND (exactly one cycle):
- credit <= credit - price; dispense = 1; item <= latched index.
- Next state is RETURN with the tick counter cleared if the remainder is > 0; otherwise IDLE.

RETURN:
- The counter increments each cycle.
- When the counter reaches TICK_CYCLES-1: change_pulse = 1, credit <= credit - 5, counter wraps to 0.
- The cycle whose pulse brings credit to 0 makes next state IDLE.
- The first change_pulse occurs TICK_CYCLES cycles after entering RETURN.

busy:
- Any coin arriving while busy is rejected (coin_reject pulses).
- buy_valid and cancel are ignored while busy, with no buy_denied.

Arithmetic and width:
- credit is 7-bit and never exceeds MAX_CREDIT. It never underflows, because deductions are gated by the compare.
- Compare and add are done at 8 bits.

Display outputs:
- avail is combinational from credit.
- bcd_tens and bcd_ones are registered, so they lag credit by one cycle.
- Both digits are always 0-9.

Decomposition:
- Package vend_pkg holds the state encoding (IDLE=0, VEND=1, RETURN=2), the coin values 5/10/50, the change unit of 5, and a price-lookup function indexed by a 2-bit select.
- One sub-module, credit_to_bcd: registered binary-to-BCD for 0-99, with clk and rst, 1-cycle latency.

Test Plan:
- Reset, then insert coin50, coin10 → credit 60; avail 4'b1111; bcd 6/0 one cycle after credit.
- From credit 60, buy_sel=1 → dispense pulse; item=1; credit 30; RETURN. With TICK_CYCLES=4, change_pulse every 4 cycles, 6 pulses total, credit 0, IDLE, busy low.
- From credit 90, coin10 → coin_reject, credit stays 90. Then coin5 → credit 95.
- coin5, coin10 and coin50 in the same cycle from 0 → credit 65. From credit 20, buy_sel=0 → buy_denied, credit stays 20.
- Same-cycle cancel + buy_valid + coin5 at credit 25 → RETURN entered, no dispense, coin_reject pulses, 5 change pulses. Buy during RETURN is ignored.
- Assert rst during RETURN at credit 15 → all outputs 0 immediately. Cancel at credit 0 → remains IDLE with no pulses.
